tick_period_meter: RTL

//   Measures the spacing, in clk cycles, between rising edges of a tick/strobe

---
 rtl/tick_period_meter_if.sv | 11 +
 rtl/tick_period_meter.sv | 50 +++++
 2 files changed

// File: rtl/tick_period_meter_if.sv
// tick_period_meter_if: enable/tick inputs and measurement outputs of the period meter
interface tick_period_meter_if #(parameter int CNT_W = 32);
    logic             enable;
    logic             tick_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;
    modport master (output enable, tick_in, input period, period_valid, locked, timeout);
    modport slave  (input enable, tick_in, output period, period_valid, locked, timeout);
endinterface

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures clk cycles between tick_in rising edges, flags loss of tick
module tick_period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100000000
) (
    input logic                 clk,
    input logic                 reset,
    tick_period_meter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ARMED, LOCKED, TIMEDOUT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic             valid_q, valid_d;
    logic             rise, measuring, en;
    always_comb begin
        en        = bus.enable;
        sync_d    = {sync_q[1:0], bus.tick_in};
        rise      = sync_q[1] & ~sync_q[2];
        measuring = state_q == ARMED || state_q == LOCKED;
        // a rise in the saturation cycle takes priority over the timeout
        state_d   = !en ? IDLE :
                    !measuring ? (rise ? ARMED : state_q) :
                    rise ? LOCKED :
                    cnt_q == LAST ? TIMEDOUT : state_q;
        cnt_d     = (!en || rise) ? '0 : cnt_q == LAST ? cnt_q : cnt_q + CNT_W'(1);
        valid_d   = en & measuring & rise;
        period_d  = valid_d ? cnt_q + CNT_W'(1) : period_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
        end
    end
    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.locked       = state_q == LOCKED;
    assign bus.timeout      = state_q == TIMEDOUT;
endmodule
